// File: rtl/aes_key_expand_seq_if.sv
// Handshake bundle between the round-key generator and the AddRoundKey consumer.
// The slave side is the key generator; the master side starts schedules and accepts keys.
interface aes_key_expand_seq_if;
   logic         start;
   logic [127:0] key_in;
   logic [127:0] rk_out;
   logic [3:0]   rk_index;
   logic         rk_valid;
   logic         rk_ready;
   logic         busy;
   logic         done;

   modport master (
      output start, key_in, rk_ready,
      input  rk_out, rk_index, rk_valid, busy, done
   );

   modport slave (
      input  start, key_in, rk_ready,
      output rk_out, rk_index, rk_valid, busy, done
   );
endinterface

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule: emits round keys 0..NUM_ROUNDS, one per valid/ready handshake.
// The next round key is derived combinationally from the registered current key.
module aes_key_expand_seq #(
   parameter int NUM_ROUNDS = 10
) (
   input logic                 clk,
   input logic                 rst_n,
   aes_key_expand_seq_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254 (254 = 2+4+...+128); maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   state_t       state_q, state_d;
   logic [127:0] rk_q, rk_d;
   logic [3:0]   idx_q, idx_d;
   logic [7:0]   rcon_q, rcon_d;
   logic         done_q, done_d;

   logic [31:0]  rot_word;
   logic [31:0]  sub_word;
   logic [31:0]  t_word;
   logic [31:0]  w0n, w1n, w2n, w3n;
   logic [127:0] rk_next;

   assign rot_word = {rk_q[23:0], rk_q[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sbox_lane
      assign sub_word[8*g +: 8] = sbox(rot_word[8*g +: 8]);
   end

   assign t_word  = sub_word ^ {rcon_q, 24'h000000};
   assign w0n     = rk_q[127:96] ^ t_word;
   assign w1n     = rk_q[95:64]  ^ w0n;
   assign w2n     = rk_q[63:32]  ^ w1n;
   assign w3n     = rk_q[31:0]   ^ w2n;
   assign rk_next = {w0n, w1n, w2n, w3n};

   always_comb begin
      state_d = state_q;
      rk_d    = rk_q;
      idx_d   = idx_q;
      rcon_d  = rcon_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               rk_d    = bus.key_in;
               idx_d   = 4'd0;
               rcon_d  = 8'h01;
            end
         end
         RUN: begin
            if (bus.rk_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  rk_d   = rk_next;
                  idx_d  = idx_q + 4'd1;
                  rcon_d = xtime(rcon_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rk_q    <= '0;
         idx_q   <= 4'd0;
         rcon_q  <= 8'h01;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rk_q    <= rk_d;
         idx_q   <= idx_d;
         rcon_q  <= rcon_d;
         done_q  <= done_d;
      end
   end

   // valid and busy coincide with the RUN state register
   assign bus.rk_out   = rk_q;
   assign bus.rk_index = idx_q;
   assign bus.rk_valid = (state_q == RUN);
   assign bus.busy     = (state_q == RUN);
   assign bus.done     = done_q;

endmodule
